// File: rtl/prng_burst_ctrl.sv
// Round-robin arbiter that seeds a shared PRNG and streams a burst of words per grant.
// Optional PRNG_REJECT_EN: reject samples whose low QW bits are >= Q and emit the QW-bit field.
module prng_burst_ctrl #(
    parameter int N  = 4,
    parameter int LW = 8,
    parameter int Q  = 3329,
    parameter int QW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [16*N-1:0]   req_seed,
    input  logic [LW*N-1:0]   req_len,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      done,
    output logic              out_valid,
    output logic [15:0]       out_data,
    input  logic              out_ready,
    output logic              prng_ivalid,
    output logic [15:0]       prng_seed,
    input  logic [15:0]       prng_data
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, SEED, WARM, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [PW-1:0] ptr, owner, sel_idx;
    logic          sel_found;
    logic [15:0]   seed_r;
    logic [LW-1:0] len_r, count;
    logic          accept;
    logic [15:0]   sample;
    logic          hs;

    // Rotating priority: first set req bit at or above ptr, wrapping.
    always_comb begin
        int j;
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!sel_found && req[j]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(j);
            end
        end
    end

`ifdef PRNG_REJECT_EN
    assign accept = (prng_data[QW-1:0] < QW'(Q));
    assign sample = {{(16-QW){1'b0}}, prng_data[QW-1:0]};
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(Q), 32'(QW)};
    assign accept     = 1'b1;
    assign sample     = prng_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        out_valid   = 1'b0;
        out_data    = 16'h0;
        prng_ivalid = 1'b0;
        prng_seed   = 16'h0;
        hs          = 1'b0;
        case (state)
            IDLE: if (sel_found) state_nxt = SEED;
            SEED: begin
                prng_ivalid = 1'b1;
                // An all-zero seed would lock the LFSR at zero forever.
                prng_seed   = (seed_r == 16'h0) ? 16'hACE1 : seed_r;
                state_nxt   = WARM;
            end
            WARM: state_nxt = (len_r == '0) ? DONE : RUN;
            RUN: begin
                if (accept) begin
                    out_valid = 1'b1;
                    out_data  = sample;
                    if (out_ready) begin
                        hs = 1'b1;
                        if (count + LW'(1) == len_r) state_nxt = DONE;
                    end else begin
                        // No PRNG enable: reload current state to hold it.
                        prng_ivalid = 1'b1;
                        prng_seed   = prng_data;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            done   <= '0;
            ptr    <= '0;
            owner  <= '0;
            seed_r <= '0;
            len_r  <= '0;
            count  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (sel_found) begin
                    grant  <= N'(1) << sel_idx;
                    owner  <= sel_idx;
                    seed_r <= req_seed[16*int'(sel_idx) +: 16];
                    len_r  <= req_len[LW*int'(sel_idx) +: LW];
                    count  <= '0;
                end
                RUN:  if (hs) count <= count + LW'(1);
                DONE: ptr <= (owner == PW'(N-1)) ? '0 : owner + PW'(1);
                default: ;
            endcase
            if (state_nxt == DONE && state != DONE) begin
                done  <= grant;
                grant <= '0;
            end
        end
    end
endmodule

// File: tb/tb_prng_burst_ctrl.sv
// Directed bench for prng_burst_ctrl with a Galois LFSR (taps 0x00AF) standing in for the PRNG.
module tb_prng_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_seed = '0;
    logic [31:0] req_len = '0;
    logic [3:0]  grant, done;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] out_data;
    logic        prng_ivalid;
    logic [15:0] prng_seed, prng_data;
    logic [15:0] lfsr = 16'h0;

    int cmp = 0;
    int errs = 0;

    always #5 clk = ~clk;

    prng_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_seed(req_seed), .req_len(req_len),
        .grant(grant), .done(done), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .prng_ivalid(prng_ivalid), .prng_seed(prng_seed),
        .prng_data(prng_data)
    );

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h00AF : 16'h0000);
    endfunction

    always @(posedge clk) lfsr <= prng_ivalid ? prng_seed : step(lfsr);
    assign prng_data = lfsr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int            idx;
        logic [15:0]   seed;
        logic [7:0]    len;
        int            stall_at;
        int            stall_n;
        int            nexp;
        int            first;
        logic [2:0][15:0] w;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int idx, input logic [15:0] seed, input logic [7:0] len,
                                input int sa, input int sn, input int ne, input int fi,
                                input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        vec_t v;
        v.idx = idx; v.seed = seed; v.len = len; v.stall_at = sa; v.stall_n = sn;
        v.nexp = ne; v.first = fi; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int n = 0, stalled = 0, first_cyc = -1, hs_cyc = -1, done_cyc = -1, gcyc = -1;
        req_seed[16*v.idx +: 16] = v.seed;
        req_len[8*v.idx +: 8]    = v.len;
        req = 4'b0001 << v.idx;
        for (int c = 0; c < 60 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (grant != 0 && gcyc < 0) begin
                gcyc = c;
                chk("grant_onehot", grant, 4'b0001 << v.idx);
                chk("grant_latency", c, 0);
                req = '0;
            end
            out_ready = !(n == v.stall_at && stalled < v.stall_n);
            #1;
            if (out_valid && first_cyc < 0) first_cyc = c;
            if (out_valid && !out_ready) begin
                stalled++;
                chk("stall_hold", out_data, v.w[n]);
                chk("stall_freeze", prng_ivalid, 1'b1);
            end else if (out_valid) begin
                if (n < 3) chk("word", out_data, v.w[n]);
                n++;
                hs_cyc = c;
            end
            if (done != 0) begin
                done_cyc = c;
                chk("done_owner", done, 4'b0001 << v.idx);
                chk("done_grant_clr", grant, 0);
            end
        end
        out_ready = 1'b1;
        chk("word_count", n, v.nexp);
        chk("done_seen", done_cyc >= 0, 1);
        if (v.nexp > 0) chk("done_after_last", done_cyc, hs_cyc + 1);
        chk("first_valid", first_cyc, v.first);
        @(negedge clk);
    endtask

    initial begin
        int order[$];
        logic [3:0] pg;
        int ok;

        vecs.push_back(mk(0, 16'h0001, 8'd3, -1, 0, 3, 2, 16'h0002, 16'h0004, 16'h0008));
        vecs.push_back(mk(0, 16'h8000, 8'd1, -1, 0, 1, 2, 16'h00AF, 16'h0, 16'h0));
`ifdef PRNG_REJECT_EN
        vecs.push_back(mk(0, 16'h0000, 8'd1, -1, 0, 1, 2, 16'h096D, 16'h0, 16'h0));
        vecs.push_back(mk(0, 16'h0700, 8'd1, -1, 0, 1, 3, 16'h0C00, 16'h0, 16'h0));
`else
        vecs.push_back(mk(0, 16'h0000, 8'd1, -1, 0, 1, 2, 16'h596D, 16'h0, 16'h0));
`endif
        vecs.push_back(mk(0, 16'h0001, 8'd3, 1, 5, 3, 2, 16'h0002, 16'h0004, 16'h0008));
        vecs.push_back(mk(1, 16'h1234, 8'd0, -1, 0, 0, -1, 16'h0, 16'h0, 16'h0));
        vecs.push_back(mk(2, 16'h00FF, 8'd2, -1, 0, 2, 2, 16'h01FE, 16'h03FC, 16'h0));

        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ivalid", prng_ivalid, 0);
        chk("rst_seed", prng_seed, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted asynchronously in the middle of a burst.
        req_seed[31:16] = 16'h0001;
        req_len[15:8]   = 8'd5;
        req = 4'b0010;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (grant != 0) req = '0;
            #1;
            if (out_valid) ok = 1;
        end
        chk("midrun_reached", ok, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ivalid", prng_ivalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("midrst_no_done", done, 0);
        end

        // All of 0,1,3 held with len 1: rotation must visit 0,1,3,0.
        req_len  = {8'd1, 8'd1, 8'd1, 8'd1};
        req_seed = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
        req = 4'b1011;
        pg = '0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            #1;
            if (done != 0) chk("rr_no_b2b", grant, 0);
            if (grant != 0 && pg == 0) begin
                for (int b = 0; b < 4; b++) if (grant[b]) order.push_back(b);
                if (order.size() == 4) req = '0;
            end
            pg = grant;
        end
        chk("rr_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("rr_g0", order[0], 0);
            chk("rr_g1", order[1], 1);
            chk("rr_g2", order[2], 3);
            chk("rr_g3", order[3], 0);
        end
        repeat (8) @(negedge clk);
        #1;
        chk("rr_idle_grant", grant, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
